fetch_queue: RTL and testbench

//  Instruction-fetch stage feeding decode. Generates fetch PCs, issues in-order pipelined requests
//  to instruction memory, and holds responses in a DEPTH-entry queue. Presents head as Pc_IF/FetchData_IF.

---
 rtl/fetch_queue_pkg.sv | 28 ++
 rtl/fetch_queue_fifo.sv | 94 +++++++++
 rtl/fetch_queue.sv | 133 +++++++++++++
 tb/tb_fetch_queue.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_queue_pkg
// Purpose : Constants and helpers shared by the instruction-fetch queue.
// Contents: NOP_INSTR, OP_J, OP_JAL, PC_STEP, jump_target(), is_jump().
// Revision: 1.0 - initial release
// ============================================================================
package fetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [5:0]  OP_J      = 6'b000010;
  localparam logic [5:0]  OP_JAL    = 6'b000011;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // J/JAL target: upper nibble of the sequential PC, then instr_index, word aligned.
  function automatic logic [31:0] jump_target(input logic [31:0] pc,
                                               input logic [25:0] idx);
    logic [31:0] seq_pc;
    seq_pc = pc + PC_STEP;
    return {seq_pc[31:28], idx, 2'b00};
  endfunction

  function automatic logic is_jump(input logic [31:0] instr);
    return (instr[31:26] == OP_J) || (instr[31:26] == OP_JAL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fetch_fifo
// Purpose : DEPTH-entry in-order fetch queue. Entries are allocated at issue
//           (pc known, data pending), filled in order by memory responses and
//           popped from the head. A single invalidate empties the queue.
// Ports   : clk, flush (async reset)
//           alloc/alloc_pc        - allocate tail entry
//           fill/fill_data        - fill oldest unfilled entry
//           pop                   - retire head entry
//           inval                 - discard every entry
//           head_filled/head_pc/head_data - head entry view
//           alloc_cnt/unfilled_cnt        - occupancy counters
// Revision: 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     flush,
  input  logic                     alloc,
  input  logic [31:0]              alloc_pc,
  input  logic                     fill,
  input  logic [31:0]              fill_data,
  input  logic                     pop,
  input  logic                     inval,
  output logic                     head_filled,
  output logic [31:0]              head_pc,
  output logic [31:0]              head_data,
  output logic [$clog2(DEPTH):0]   alloc_cnt,
  output logic [$clog2(DEPTH):0]   unfilled_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [AW-1:0]    head_ptr;
  logic [AW-1:0]    tail_ptr;
  logic [AW-1:0]    fill_ptr;

  // Control state: pointers, counters and per-entry filled flags.
  always_ff @(posedge clk or posedge flush) begin
    if (flush) begin
      head_ptr     <= '0;
      tail_ptr     <= '0;
      fill_ptr     <= '0;
      alloc_cnt    <= '0;
      unfilled_cnt <= '0;
      filled       <= '0;
    end else if (inval) begin
      head_ptr     <= '0;
      tail_ptr     <= '0;
      fill_ptr     <= '0;
      alloc_cnt    <= '0;
      unfilled_cnt <= '0;
      filled       <= '0;
    end else begin
      if (alloc) begin
        filled[tail_ptr] <= 1'b0;
        tail_ptr         <= tail_ptr + 1'b1;
      end
      // The fill target is always an allocated, unfilled entry, so it never
      // coincides with the tail slot being allocated or the head being popped.
      if (fill) begin
        filled[fill_ptr] <= 1'b1;
        fill_ptr         <= fill_ptr + 1'b1;
      end
      if (pop) begin
        head_ptr <= head_ptr + 1'b1;
      end
      alloc_cnt    <= alloc_cnt + CW'(alloc) - CW'(pop);
      unfilled_cnt <= unfilled_cnt + CW'(alloc) - CW'(fill);
    end
  end

  // Payload storage needs no reset: every entry is qualified by filled/alloc_cnt.
  always_ff @(posedge clk) begin
    if (alloc && !inval) begin
      pc_mem[tail_ptr] <= alloc_pc;
    end
    if (fill && !inval) begin
      data_mem[fill_ptr] <= fill_data;
    end
  end

  assign head_filled = (alloc_cnt != '0) && filled[head_ptr];
  assign head_pc     = pc_mem[head_ptr];
  assign head_data   = data_mem[head_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : fetch_queue
// Purpose : Instruction-fetch stage. Issues pipelined in-order requests to
//           instruction memory, buffers responses in a DEPTH-entry queue and
//           presents the head to decode. Applies decode jumps and execute
//           redirects, draining responses that belong to discarded requests.
// Ports   : clk, flush (async active-high reset)
//           AnyStall, Jump_IDM1, JumpTgt_IDM1     - decode controls
//           Redirect_EX, RedirectPc_EX           - execute redirect
//           ImemReq_IF, ImemAddr_IF, ImemGnt     - request channel
//           ImemRspValid, ImemRspData            - in-order response channel
//           Pc_IF, FetchData_IF, FetchEmpty_IF   - presented instruction
// Revision: 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        flush,
  input  logic        AnyStall,
  input  logic        Jump_IDM1,
  input  logic [25:0] JumpTgt_IDM1,
  input  logic        Redirect_EX,
  input  logic [31:0] RedirectPc_EX,
  output logic        ImemReq_IF,
  output logic [31:0] ImemAddr_IF,
  input  logic        ImemGnt,
  input  logic        ImemRspValid,
  input  logic [31:0] ImemRspData,
  output logic [31:0] Pc_IF,
  output logic [31:0] FetchData_IF,
  output logic        FetchEmpty_IF
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   last_pc;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] alloc_cnt;
  logic [CW-1:0] unfilled_cnt;
  logic          head_filled;
  logic [31:0]   head_pc;
  logic [31:0]   head_data;
  logic [OW-1:0] occupancy;
  logic          full;
  logic          take_head;
  logic          take_jump;
  logic          invalidate;
  logic          issue;
  logic          rsp_fill;
  logic          rsp_drop;

  always_comb begin
    // Outstanding responses still owed by memory bound further issue.
    occupancy  = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
    full       = (occupancy >= OW'(DEPTH));
    take_head  = head_filled & ~AnyStall & ~Redirect_EX;
    take_jump  = take_head & Jump_IDM1;
    invalidate = Redirect_EX | take_jump;
    // Request is withheld on a taken jump so no request is ever issued
    // to the discarded sequential path.
    ImemReq_IF = ~flush & ~full & ~Redirect_EX & ~take_jump;
    issue      = ImemReq_IF & ImemGnt;
    rsp_drop   = ImemRspValid & (drop_cnt != '0);
    rsp_fill   = ImemRspValid & (drop_cnt == '0);
    ImemAddr_IF   = fetch_pc;
    FetchEmpty_IF = ~head_filled;
    Pc_IF         = head_filled ? head_pc   : last_pc;
    FetchData_IF  = head_filled ? head_data : NOP_INSTR;
  end

  always_ff @(posedge clk or posedge flush) begin
    if (flush) begin
      fetch_pc <= RESET_PC;
      last_pc  <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      if (Redirect_EX) begin
        fetch_pc <= RedirectPc_EX;
      end else if (take_jump) begin
        fetch_pc <= jump_target(head_pc, JumpTgt_IDM1);
      end else if (issue) begin
        fetch_pc <= fetch_pc + PC_STEP;
      end

      if (head_filled) begin
        last_pc <= head_pc;
      end

      // Every discarded unfilled entry still has a response coming; one that
      // arrives this same cycle is already consumed here, whether it retired
      // an older drop or belonged to a discarded entry.
      if (invalidate) begin
        drop_cnt <= drop_cnt + unfilled_cnt - CW'(ImemRspValid);
      end else if (rsp_drop) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .flush        (flush),
    .alloc        (issue),
    .alloc_pc     (fetch_pc),
    .fill         (rsp_fill),
    .fill_data    (ImemRspData),
    .pop          (take_head),
    .inval        (invalidate),
    .head_filled  (head_filled),
    .head_pc      (head_pc),
    .head_data    (head_data),
    .alloc_cnt    (alloc_cnt),
    .unfilled_cnt (unfilled_cnt)
  );

`ifndef SYNTHESIS
  rsp_has_owner: assert property (@(posedge clk) disable iff (flush)
    ImemRspValid |-> ((drop_cnt != '0) || (unfilled_cnt != '0)));
  jump_on_jump: assert property (@(posedge clk) disable iff (flush)
    take_jump |-> is_jump(head_data));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_fetch_queue
// Purpose : Directed self-checking bench for fetch_queue with an in-order
//           instruction-memory model (programmable latency, grant, hold).
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic        clk = 1'b0;
  logic        flush = 1'b1;
  logic        AnyStall = 1'b0;
  logic        Jump_IDM1 = 1'b0;
  logic [25:0] JumpTgt_IDM1 = '0;
  logic        Redirect_EX = 1'b0;
  logic [31:0] RedirectPc_EX = '0;
  logic        ImemGnt = 1'b1;
  logic        ImemRspValid = 1'b0;
  logic [31:0] ImemRspData = '0;
  logic        ImemReq_IF;
  logic [31:0] ImemAddr_IF;
  logic [31:0] Pc_IF;
  logic [31:0] FetchData_IF;
  logic        FetchEmpty_IF;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .flush         (flush),
    .AnyStall      (AnyStall),
    .Jump_IDM1     (Jump_IDM1),
    .JumpTgt_IDM1  (JumpTgt_IDM1),
    .Redirect_EX   (Redirect_EX),
    .RedirectPc_EX (RedirectPc_EX),
    .ImemReq_IF    (ImemReq_IF),
    .ImemAddr_IF   (ImemAddr_IF),
    .ImemGnt       (ImemGnt),
    .ImemRspValid  (ImemRspValid),
    .ImemRspData   (ImemRspData),
    .Pc_IF         (Pc_IF),
    .FetchData_IF  (FetchData_IF),
    .FetchEmpty_IF (FetchEmpty_IF)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- instruction memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          rdy;
  } req_t;

  req_t pend[$];
  int   cyc = 0;
  int   last_rdy = 0;
  int   lat_min = 1;
  int   lat_max = 1;
  bit   rand_gnt = 0;
  bit   hold = 0;
  bit   jmp_en = 0;
  bit   saw_40 = 0;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    if (jmp_en && a == 32'h10) return {OP_J, 26'h10};
    return ~a;
  endfunction

  always @(posedge clk or posedge flush) begin
    if (flush) begin
      pend.delete();
      last_rdy = 0;
    end else begin
      cyc++;
      if (ImemRspValid) void'(pend.pop_front());
      if (ImemReq_IF && ImemGnt) begin
        req_t r;
        int   l;
        l      = $urandom_range(lat_max, lat_min);
        r.addr = ImemAddr_IF;
        r.rdy  = cyc + l - 1;
        if (r.rdy < last_rdy) r.rdy = last_rdy;
        last_rdy = r.rdy;
        pend.push_back(r);
        if (ImemAddr_IF == 32'h40) saw_40 = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (flush || hold || pend.size() == 0 || pend[0].rdy > cyc) begin
      ImemRspValid = 1'b0;
      ImemRspData  = '0;
    end else begin
      ImemRspValid = 1'b1;
      ImemRspData  = instr_at(pend[0].addr);
    end
    if (rand_gnt) ImemGnt = 1'($urandom_range(1, 0));
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    flush = 1'b1;
    AnyStall = 1'b0; Jump_IDM1 = 1'b0; Redirect_EX = 1'b0;
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Wait (bounded) for the first presented instruction, then expect n
  // consecutive sequential instructions with no empty cycle in between.
  task automatic stream_check(input string tag, input logic [31:0] start, input int n);
    int          waited;
    logic [31:0] pc;
    waited = 0;
    pc     = start;
    @(negedge clk);
    while (FetchEmpty_IF && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    check({tag, "_wait"}, 32'(waited < 20), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      check({tag, "_pc"}, Pc_IF, pc);
      check({tag, "_data"}, FetchData_IF, instr_at(pc));
      check({tag, "_empty"}, 32'(FetchEmpty_IF), 32'd0);
      pc += 32'd4;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] last_p;

    // ---- 1: reset state, then back-to-back stream ----
    @(negedge clk);
    check("rst_pc", Pc_IF, 32'h0);
    check("rst_data", FetchData_IF, NOP_INSTR);
    check("rst_empty", 32'(FetchEmpty_IF), 32'd1);
    check("rst_addr", ImemAddr_IF, 32'h0);
    check("rst_req", 32'(ImemReq_IF), 32'd0);
    flush = 1'b0;
    #1;
    check("t1_req", 32'(ImemReq_IF), 32'd1);
    stream_check("t1", 32'h0, 8);

    // ---- 2: stall with full queue ----
    AnyStall = 1'b1;               // head 0x1C held from here
    for (int s = 1; s <= 5; s++) begin
      @(negedge clk);
      check("t2_pc", Pc_IF, 32'h1C);
      check("t2_data", FetchData_IF, ~32'h1C);
      if (s >= 2) check("t2_req", 32'(ImemReq_IF), 32'd0);
    end
    AnyStall = 1'b0;
    stream_check("t2r", 32'h20, 6);

    // ---- 3: J at 0x10 -> 0x40 ----
    jmp_en = 1;
    do_reset();
    stream_check("t3", 32'h0, 4);
    @(negedge clk);
    check("t3_jpc", Pc_IF, 32'h10);
    check("t3_jdata", FetchData_IF, {OP_J, 26'h10});
    Jump_IDM1 = 1'b1; JumpTgt_IDM1 = 26'h10;
    @(posedge clk); #1 Jump_IDM1 = 1'b0;
    @(negedge clk);
    check("t3_addr", ImemAddr_IF, 32'h40);
    check("t3_req", 32'(ImemReq_IF), 32'd1);
    check("t3_gap", 32'(FetchEmpty_IF), 32'd1);
    stream_check("t3j", 32'h40, 4);

    // ---- 4: redirect with 3 unfilled in flight ----
    jmp_en = 0;
    hold = 1;
    ImemGnt = 1'b1;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t4_empty", 32'(FetchEmpty_IF), 32'd1);
    ImemGnt = 1'b0;
    Redirect_EX = 1'b1; RedirectPc_EX = 32'h200;
    #1 check("t4_noreq", 32'(ImemReq_IF), 32'd0);
    @(negedge clk);
    Redirect_EX = 1'b0;
    ImemGnt = 1'b1;
    #1;
    check("t4_addr", ImemAddr_IF, 32'h200);
    check("t4_req", 32'(ImemReq_IF), 32'd1);
    @(posedge clk); #1 hold = 0;
    stream_check("t4", 32'h200, 4);

    // ---- 5: redirect and jump in the same cycle ----
    jmp_en = 1;
    do_reset();
    saw_40 = 0;
    stream_check("t5", 32'h0, 4);
    @(negedge clk);
    check("t5_jpc", Pc_IF, 32'h10);
    Jump_IDM1 = 1'b1; JumpTgt_IDM1 = 26'h10;
    Redirect_EX = 1'b1; RedirectPc_EX = 32'h300;
    @(posedge clk); #1 Jump_IDM1 = 1'b0; Redirect_EX = 1'b0;
    @(negedge clk);
    check("t5_addr", ImemAddr_IF, 32'h300);
    stream_check("t5r", 32'h300, 4);
    check("t5_no_jtgt", 32'(saw_40), 32'd0);

    // ---- 6: random grant / latency / stall vs PC model ----
    jmp_en = 0;
    lat_min = 1; lat_max = 4;
    rand_gnt = 1;
    do_reset();
    exp_pc = 32'h0;
    last_p = 32'h0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!FetchEmpty_IF) begin
        check("t6_pc", Pc_IF, exp_pc);
        check("t6_data", FetchData_IF, ~exp_pc);
        last_p = exp_pc;
      end else begin
        check("t6_nop", FetchData_IF, NOP_INSTR);
        check("t6_hold_pc", Pc_IF, last_p);
      end
      AnyStall = ($urandom_range(3, 0) == 0);
      if (!FetchEmpty_IF && !AnyStall) exp_pc += 32'd4;
    end
    check("t6_progress", 32'(exp_pc >= 32'd160), 32'd1);
    rand_gnt = 0;
    AnyStall = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
